// File: rtl/lsm_pkg.sv
// Fixed-point types, saturating arithmetic and FSM states shared by the LSM moment accumulator.
package lsm_pkg;

    localparam int unsigned FIX_W     = 32;
    localparam int unsigned FIX_QFRAC = 16;
    localparam int unsigned ACC_W     = 48;

    typedef logic signed [FIX_W-1:0] fix_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    localparam fix_t FIX_ONE = fix_t'(1) << FIX_QFRAC;
    localparam fix_t FIX_MAX = {1'b0, {(FIX_W-1){1'b1}}};
    localparam fix_t FIX_MIN = {1'b1, {(FIX_W-1){1'b0}}};
    localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StAccum, StDrain, StHold} state_e;

    // Q-format multiply: arithmetic shift (floor), then clamp to the fix_t range.
    function automatic fix_t sat_mul_q(input fix_t a, input fix_t b, output logic sat);
        logic signed [2*FIX_W-1:0] a_w, b_w, prod;
        a_w  = {{FIX_W{a[FIX_W-1]}}, a};
        b_w  = {{FIX_W{b[FIX_W-1]}}, b};
        prod = (a_w * b_w) >>> FIX_QFRAC;
        sat  = !((&prod[2*FIX_W-1:FIX_W-1]) || !(|prod[2*FIX_W-1:FIX_W-1]));
        if (sat) begin
            return prod[2*FIX_W-1] ? FIX_MIN : FIX_MAX;
        end
        return prod[FIX_W-1:0];
    endfunction

    function automatic acc_t sat_add(input acc_t a, input acc_t b, output logic sat);
        logic [ACC_W:0] sum;
        sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        sat = sum[ACC_W] != sum[ACC_W-1];
        if (sat) begin
            return sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        return sum[ACC_W-1:0];
    endfunction

    function automatic acc_t fix_to_acc(input fix_t v);
        return {{(ACC_W-FIX_W){v[FIX_W-1]}}, v};
    endfunction

endpackage

// File: rtl/lsm_power_chain.sv
// Pipelined x^0..x^(2*DEG) and x^k*y generator; stage s forms x^(s+1) and, for s<=DEG, x^s*y.
module lsm_power_chain
    import lsm_pkg::*;
#(
    parameter int unsigned DEG = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_i,
    input  logic                          itm_i,
    input  logic [FIX_W-1:0]              x_i,
    input  logic [FIX_W-1:0]              y_i,
    output logic                          valid_o,
    output logic                          itm_o,
    output logic                          sat_o,
    output logic [(2*DEG+1)*FIX_W-1:0]    pow_o,
    output logic [(DEG+1)*FIX_W-1:0]      prd_o
);

    localparam int unsigned NSTG = 2 * DEG;
    localparam int unsigned NPOW = 2 * DEG + 1;
    localparam int unsigned NPRD = DEG + 1;

    logic vld_d [NSTG];
    logic vld_q [NSTG];
    logic itm_d [NSTG];
    logic itm_q [NSTG];
    logic sat_d [NSTG];
    logic sat_q [NSTG];
    fix_t x_d   [NSTG];
    fix_t x_q   [NSTG];
    fix_t y_d   [NSTG];
    fix_t y_q   [NSTG];
    fix_t pow_d [NSTG][NPOW];
    fix_t pow_q [NSTG][NPOW];
    fix_t prd_d [NSTG][NPRD];
    fix_t prd_q [NSTG][NPRD];
    logic mul_sat [NSTG];
    logic prd_sat [NPRD];

    always_comb begin
        vld_d[0] = valid_i;
        itm_d[0] = itm_i;
        sat_d[0] = 1'b0;
        x_d[0]   = x_i;
        y_d[0]   = y_i;
        for (int k = 0; k < NPOW; k++) pow_d[0][k] = (k == 0) ? FIX_ONE : '0;
        for (int k = 0; k < NPRD; k++) prd_d[0][k] = '0;
        for (int s = 1; s < NSTG; s++) begin
            vld_d[s] = vld_q[s-1];
            itm_d[s] = itm_q[s-1];
            sat_d[s] = sat_q[s-1];
            x_d[s]   = x_q[s-1];
            y_d[s]   = y_q[s-1];
            for (int k = 0; k < NPOW; k++) pow_d[s][k] = pow_q[s-1][k];
            for (int k = 0; k < NPRD; k++) prd_d[s][k] = prd_q[s-1][k];
        end
        for (int s = 0; s < NSTG; s++) begin
            pow_d[s][s+1] = sat_mul_q(pow_d[s][s], x_d[s], mul_sat[s]);
            sat_d[s]      = sat_d[s] | mul_sat[s];
        end
        for (int s = 0; s < NPRD; s++) begin
            prd_d[s][s] = sat_mul_q(pow_d[s][s], y_d[s], prd_sat[s]);
            sat_d[s]    = sat_d[s] | prd_sat[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSTG; s++) begin
                vld_q[s] <= 1'b0;
                itm_q[s] <= 1'b0;
                sat_q[s] <= 1'b0;
                x_q[s]   <= '0;
                y_q[s]   <= '0;
                for (int k = 0; k < NPOW; k++) pow_q[s][k] <= '0;
                for (int k = 0; k < NPRD; k++) prd_q[s][k] <= '0;
            end
        end else begin
            for (int s = 0; s < NSTG; s++) begin
                vld_q[s] <= vld_d[s];
                itm_q[s] <= itm_d[s];
                sat_q[s] <= sat_d[s];
                x_q[s]   <= x_d[s];
                y_q[s]   <= y_d[s];
                for (int k = 0; k < NPOW; k++) pow_q[s][k] <= pow_d[s][k];
                for (int k = 0; k < NPRD; k++) prd_q[s][k] <= prd_d[s][k];
            end
        end
    end

    always_comb begin
        valid_o = vld_q[NSTG-1];
        itm_o   = itm_q[NSTG-1];
        sat_o   = sat_q[NSTG-1];
        pow_o   = '0;
        prd_o   = '0;
        for (int k = 0; k < NPOW; k++) pow_o[k*FIX_W +: FIX_W] = pow_q[NSTG-1][k];
        for (int k = 0; k < NPRD; k++) prd_o[k*FIX_W +: FIX_W] = prd_q[NSTG-1][k];
    end

endmodule

// File: rtl/lsm_moment_accumulator.sv
// Streams (x, y, itm) samples and accumulates LSM normal-equation moments S[k], T[k] per batch.
module lsm_moment_accumulator
    import lsm_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned QINT      = 16,
    parameter int unsigned QFRAC     = 16,
    parameter int unsigned DEG       = 2,
    parameter int unsigned N_SAMPLES = 1024,
    parameter int unsigned ACC_WIDTH = 48,
    localparam int unsigned CNT_W    = $clog2(N_SAMPLES + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             valid_in,
    output logic                             ready_out,
    input  logic [WIDTH-1:0]                 x_in,
    input  logic [WIDTH-1:0]                 y_in,
    input  logic                             itm_in,
    input  logic                             last_in,
    output logic                             valid_out,
    input  logic                             ready_in,
    output logic [(2*DEG+1)*ACC_WIDTH-1:0]   s_out,
    output logic [(DEG+1)*ACC_WIDTH-1:0]     t_out,
    output logic [CNT_W-1:0]                 n_used,
    output logic                             sat_out
);

    localparam int unsigned NS      = 2 * DEG + 1;
    localparam int unsigned NT      = DEG + 1;
    localparam int unsigned L       = 2 * DEG;
    localparam int unsigned DRAIN_W = $clog2(L + 1);

    // The arithmetic types live in lsm_pkg; the width parameters must agree with them.
    if (WIDTH != FIX_W || QFRAC != FIX_QFRAC || QINT + QFRAC != WIDTH || ACC_WIDTH != ACC_W
        || DEG < 1 || DEG > 4) begin : g_cfg_err
        $error("lsm_moment_accumulator: unsupported parameter set");
    end

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     batch_cnt_q, batch_cnt_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]     n_used_q, n_used_d;
    logic                 sat_q, sat_d;
    acc_t                 s_acc_q [NS];
    acc_t                 s_acc_d [NS];
    acc_t                 t_acc_q [NT];
    acc_t                 t_acc_d [NT];
    logic                 s_sat [NS];
    logic                 t_sat [NT];
    fix_t                 pow_w [NS];
    fix_t                 prd_w [NT];

    logic                 accept, close, hs;
    logic                 ch_valid, ch_itm, ch_sat;
    logic [NS*FIX_W-1:0]  ch_pow;
    logic [NT*FIX_W-1:0]  ch_prd;

    assign accept = valid_in && ready_out;
    assign close  = accept && (batch_cnt_q == CNT_W'(N_SAMPLES - 1) || last_in);
    assign hs     = (state_q == StHold) && ready_in;

    lsm_power_chain #(
        .DEG (DEG)
    ) u_chain (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (accept),
        .itm_i   (itm_in),
        .x_i     (x_in),
        .y_i     (y_in),
        .valid_o (ch_valid),
        .itm_o   (ch_itm),
        .sat_o   (ch_sat),
        .pow_o   (ch_pow),
        .prd_o   (ch_prd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StAccum;
            StAccum: if (close) state_d = StDrain;
            StDrain: if (drain_cnt_q == DRAIN_W'(L)) state_d = StHold;
            StHold:  if (ready_in) state_d = StAccum;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready_out = (state_q == StAccum);
        valid_out = (state_q == StHold);
    end

    always_comb begin
        drain_cnt_d = (state_q == StDrain) ? drain_cnt_q + DRAIN_W'(1) : '0;
        batch_cnt_d = batch_cnt_q;
        if (close) begin
            batch_cnt_d = '0;
        end else if (accept) begin
            batch_cnt_d = batch_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        for (int k = 0; k < NS; k++) pow_w[k] = ch_pow[k*FIX_W +: FIX_W];
        for (int k = 0; k < NT; k++) prd_w[k] = ch_prd[k*FIX_W +: FIX_W];
    end

    // Samples retiring from the chain carry itm; non-itm samples leave the bank untouched.
    always_comb begin
        s_acc_d  = s_acc_q;
        t_acc_d  = t_acc_q;
        n_used_d = n_used_q;
        sat_d    = sat_q;
        for (int k = 0; k < NS; k++) s_sat[k] = 1'b0;
        for (int k = 0; k < NT; k++) t_sat[k] = 1'b0;
        if (hs) begin
            for (int k = 0; k < NS; k++) s_acc_d[k] = '0;
            for (int k = 0; k < NT; k++) t_acc_d[k] = '0;
            n_used_d = '0;
            sat_d    = 1'b0;
        end else if (ch_valid && ch_itm) begin
            for (int k = 0; k < NS; k++) begin
                s_acc_d[k] = sat_add(s_acc_q[k], fix_to_acc(pow_w[k]), s_sat[k]);
                sat_d      = sat_d | s_sat[k];
            end
            for (int k = 0; k < NT; k++) begin
                t_acc_d[k] = sat_add(t_acc_q[k], fix_to_acc(prd_w[k]), t_sat[k]);
                sat_d      = sat_d | t_sat[k];
            end
            n_used_d = n_used_q + CNT_W'(1);
            sat_d    = sat_d | ch_sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            batch_cnt_q <= '0;
            drain_cnt_q <= '0;
            n_used_q    <= '0;
            sat_q       <= 1'b0;
            for (int k = 0; k < NS; k++) s_acc_q[k] <= '0;
            for (int k = 0; k < NT; k++) t_acc_q[k] <= '0;
        end else begin
            batch_cnt_q <= batch_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            n_used_q    <= n_used_d;
            sat_q       <= sat_d;
            for (int k = 0; k < NS; k++) s_acc_q[k] <= s_acc_d[k];
            for (int k = 0; k < NT; k++) t_acc_q[k] <= t_acc_d[k];
        end
    end

    always_comb begin
        s_out = '0;
        t_out = '0;
        for (int k = 0; k < NS; k++) s_out[k*ACC_WIDTH +: ACC_WIDTH] = s_acc_q[k];
        for (int k = 0; k < NT; k++) t_out[k*ACC_WIDTH +: ACC_WIDTH] = t_acc_q[k];
        n_used  = n_used_q;
        sat_out = sat_q;
    end

endmodule
